// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding a UART transmitter: buffers producer bursts and
// issues one wr_en pulse per byte, pacing on tx_busy with a bounded wait for busy to rise.
module uart_tx_fifo #(
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        uart_din,
    output logic              uart_wr_en,
    input  logic              uart_tx_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_IDLE
    } state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        din_q, din_d;
    logic              wr_en_q, wr_en_d;
    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              push, pop;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign uart_din   = din_q;
    assign uart_wr_en = wr_en_q;

    // Full is judged on the pre-edge count, so a write at full loses even if a pop happens now.
    assign push = wr_valid && !full && !flush;
    assign pop  = (state_q == IDLE) && !empty && !uart_tx_busy;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin : fifo_next
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = wr_valid && full && !flush;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    din_d   = mem_q[rd_ptr_q];
                    wr_en_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never raises busy is treated as having sent the byte.
                if (uart_tx_busy)          state_d = WAIT_IDLE;
                else if (tmo_q == TMO_MAX) state_d = IDLE;
                else                       tmo_d   = tmo_q + 1'b1;
            end
            WAIT_IDLE: begin
                if (!uart_tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            din_q      <= 8'h00;
            wr_en_q    <= 1'b0;
            state_q    <= IDLE;
            tmo_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            din_q      <= din_d;
            wr_en_q    <= wr_en_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_50m) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide transmit buffer that sits directly upstream of the uart block.
- Accepts bursts of bytes from a producer at clock rate and stores them in a power-of-two FIFO.
- Drains the FIFO one byte at a time into the uart transmitter's din/wr_en inputs, pacing itself on tx_busy.
- Lets software or other logic queue a whole message without watching the transmitter.

Parameters:
- ADDR_W, 4, log2 of FIFO depth (depth = 2^ADDR_W = 16 entries).
- BUSY_TIMEOUT, 4, cycles to wait for uart_tx_busy to rise after a wr_en pulse before giving up on that handshake.

Ports:
- clk_50m  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_data  input  8  byte to enqueue.
- wr_valid  input  1  enqueue request, sampled each rising edge.
- flush  input  1  synchronous clear of FIFO contents.
- full  output  1  FIFO holds 2^ADDR_W bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_W+1  current occupancy.
- overflow  output  1  one-cycle pulse: a write was dropped because FIFO full.
- uart_din  output  8  byte presented to uart din.
- uart_wr_en  output  1  one-cycle start pulse to uart wr_en.
- uart_tx_busy  input  1  from uart tx_busy.

Behaviour:
- Reset (async, rst=1):
  - FIFO state: rd_ptr=0, wr_ptr=0, count=0.
  - Outputs: empty=1, full=0, overflow=0, uart_din=8'h00, uart_wr_en=0.
  - FSM: IDLE, timeout counter=0.
  - Reset asserted mid-transmit abandons the byte; queued contents are lost.
- Storage: 2^ADDR_W x 8 register array.
  - Pointers are ADDR_W bits and wrap modulo depth.
  - count is ADDR_W+1 bits and ranges 0..2^ADDR_W.
- full and empty are combinational from registered count: full = (count == 2^ADDR_W), empty = (count == 0).
- Write: when wr_valid=1, full=0 and flush=0, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Write while full: data dropped, pointers unchanged, overflow=1 for the next cycle only.
  - Full is evaluated before any same-cycle pop, so a write at full is dropped even if the FSM pops that cycle.
- Pop: performed only by the FSM in IDLE.
  - Same-cycle push and pop leaves count unchanged.
  - Push into empty with no pop increments count. The FSM sees the byte on the following edge.
- flush=1: rd_ptr, wr_ptr and count are cleared on that edge, and a same-cycle write is dropped without an overflow pulse.
  - flush does not touch the FSM, uart_din or an in-flight handshake.
- FSM states:
  - IDLE: if count>0 and uart_tx_busy=0, then on this edge uart_din <= mem[rd_ptr], rd_ptr increments, count decrements, uart_wr_en <= 1, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: uart_wr_en <= 0, timeout counter <= 0, go to WAIT_BUSY. uart_wr_en is therefore high for exactly one cycle.
  - WAIT_BUSY:
    - If uart_tx_busy=1, go to WAIT_IDLE.
    - Otherwise increment the timeout counter.
    - When the counter reaches BUSY_TIMEOUT, go to IDLE; the byte is treated as sent and is not retried.
  - WAIT_IDLE: when uart_tx_busy=0, go to IDLE.
- Latency:
  - A byte written at edge N into an empty FIFO with the transmitter idle drives uart_wr_en=1 and the valid uart_din in the cycle after edge N+1.
  - Back-to-back bytes: the next wr_en comes one edge after tx_busy falls, then the IDLE decision edge.
- uart_din holds its value until the next pop, and is stable while uart_wr_en is high.
- Byte order: strictly FIFO. Bytes are never duplicated or reordered.

Test Plan:
- Single byte: reset, write 8'hA5, uart idle -> exactly one uart_wr_en pulse 2 edges after the write with uart_din=8'hA5; count returns to 0; empty=1.
- Burst to full: write 0x00..0x0F on consecutive cycles while uart_tx_busy is held high -> full=1, count=16. Release busy and model the uart -> 16 wr_en pulses in order 0x00..0x0F.
- Overflow: with FIFO full, write 8'h77 -> overflow high for exactly one cycle, count stays 16, and 8'h77 is never presented on uart_din.
- Flush: queue 5 bytes with busy high, then pulse flush together with a write -> count=0, empty=1, no overflow. After busy drops, no further wr_en pulses occur.
- Timeout: uart_tx_busy tied 0 and 2 bytes queued -> the wr_en pulses for the two bytes are spaced by 1 (IDLE) + 1 (ISSUE) + BUSY_TIMEOUT (4) + 1 (IDLE) = 7 cycles, and both bytes appear in order.
- Loopback: instantiate with the real uart, tx tied to rx, and enqueue 0x00..0xFF, refilling whenever full=0 -> the receiver's dout matches each byte in order and overflow never pulses. Assert rst mid-frame -> all outputs return to their reset values immediately.
